// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: latches decode fields, bypasses EX/MEM/WB results into the
// operands, stalls one cycle on load-use, honours execute back-pressure and flush.
module id_ex_operand_stage #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ID_VALID,
  output logic              ID_READY,
  input  logic [31:0]       ID_PC,
  input  logic [31:0]       ID_IMM,
  input  logic [4:0]        ID_RS1,
  input  logic [4:0]        ID_RS2,
  input  logic [4:0]        ID_RD,
  input  logic              ID_USES_RS1,
  input  logic              ID_USES_RS2,
  input  logic              ID_WE,
  input  logic              ID_IS_LOAD,
  input  logic [CTRL_W-1:0] ID_CTRL,
  input  logic [31:0]       RF_DATA1,
  input  logic [31:0]       RF_DATA2,
  input  logic [31:0]       EX_RESULT,
  input  logic              MEM_VALID,
  input  logic              MEM_WE,
  input  logic [4:0]        MEM_RD,
  input  logic [31:0]       MEM_DATA,
  input  logic              WB_VALID,
  input  logic              WB_WE,
  input  logic [4:0]        WB_RD,
  input  logic [31:0]       WB_DATA,
  input  logic              EX_READY,
  input  logic              FLUSH,
  output logic              EX_VALID,
  output logic [31:0]       EX_PC,
  output logic [31:0]       EX_IMM,
  output logic [31:0]       EX_OP1,
  output logic [31:0]       EX_OP2,
  output logic [4:0]        EX_RD,
  output logic              EX_WE,
  output logic              EX_IS_LOAD,
  output logic [CTRL_W-1:0] EX_CTRL,
  output logic [CNT_W-1:0]  BUBBLE_CNT
);

  logic              valid_q;
  logic [31:0]       pc_q, imm_q, op1_q, op2_q;
  logic [4:0]        rd_q;
  logic              we_q, ld_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              hz;
  logic [31:0]       op1_d, op2_d;

  function automatic logic [31:0] sel_op(
    input logic [4:0]  rs,
    input logic [31:0] rf,
    input logic        ex_v, ex_we, ex_ld,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_res,
    input logic        mem_v, mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_data,
    input logic        wb_v, wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    logic [31:0] r;
    r = rf;
    if (rs == 5'd0)                                  r = 32'd0;
    else if (ex_v && ex_we && !ex_ld && ex_rd == rs) r = ex_res;
    else if (mem_v && mem_we && mem_rd == rs)        r = mem_data;
    else if (wb_v && wb_we && wb_rd == rs)           r = wb_data;
    return r;
  endfunction

  // A load in EX cannot forward yet: the dependent instruction waits one cycle
  // and then picks the load data from MEM.
  always_comb begin
    hz = valid_q && ld_q && we_q && (rd_q != 5'd0) &&
         ((ID_USES_RS1 && ID_RS1 == rd_q) || (ID_USES_RS2 && ID_RS2 == rd_q));
  end

  // Handshake: decode transfers on ID_VALID & ID_READY at a rising edge; the EX
  // bundle transfers on EX_VALID & EX_READY and is held unchanged while EX_READY=0.
  assign ID_READY = RESET && EX_READY && !hz;

  always_comb begin
    op1_d = sel_op(ID_RS1, RF_DATA1, valid_q, we_q, ld_q, rd_q, EX_RESULT,
                   MEM_VALID, MEM_WE, MEM_RD, MEM_DATA, WB_VALID, WB_WE, WB_RD, WB_DATA);
    op2_d = sel_op(ID_RS2, RF_DATA2, valid_q, we_q, ld_q, rd_q, EX_RESULT,
                   MEM_VALID, MEM_WE, MEM_RD, MEM_DATA, WB_VALID, WB_WE, WB_RD, WB_DATA);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else if (FLUSH) begin
      valid_q <= 1'b0;
    end else if (!EX_READY) begin
      valid_q <= valid_q;
    end else if (hz) begin
      valid_q <= 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end else if (ID_VALID) begin
      valid_q <= 1'b1;
      pc_q    <= ID_PC;
      imm_q   <= ID_IMM;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= ID_RD;
      we_q    <= ID_WE;
      ld_q    <= ID_IS_LOAD;
      ctrl_q  <= ID_CTRL;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign EX_VALID   = valid_q;
  assign EX_PC      = pc_q;
  assign EX_IMM     = imm_q;
  assign EX_OP1     = op1_q;
  assign EX_OP2     = op2_q;
  assign EX_RD      = rd_q;
  assign EX_WE      = we_q;
  assign EX_IS_LOAD = ld_q;
  assign EX_CTRL    = ctrl_q;
  assign BUBBLE_CNT = cnt_q;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage sitting directly downstream of the register file: captures the two register-file read ports each cycle, resolves data hazards by bypassing from EX, MEM and WB results, and presents a registered operand bundle to the execute stage. It detects load-use hazards and inserts a one-cycle bubble, honours back-pressure from execute, and drops its contents on a branch/jump flush. A saturating counter records inserted bubbles for performance checks.

## Interface
- CTRL_W, 16, width of the opaque decode control bundle passed to EX
- CNT_W, 16, width of the bubble counter
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-low reset
- ID_VALID  in  1  decode presents an instruction
- ID_READY  out  1  stage accepts the decode instruction this cycle
- ID_PC, ID_IMM  in  32 each  instruction PC, sign-extended immediate
- ID_RS1, ID_RS2, ID_RD  in  5 each  register addresses (ID_RS1/ID_RS2 also drive register-file OUT1ADDRESS/OUT2ADDRESS)
- ID_USES_RS1, ID_USES_RS2  in  1 each  instruction actually reads rs1/rs2
- ID_WE, ID_IS_LOAD  in  1 each  instruction writes rd / is a load
- ID_CTRL  in  CTRL_W  control bundle, passed through unmodified
- RF_DATA1, RF_DATA2  in  32 each  register-file read data for ID_RS1/ID_RS2, valid in same cycle
- EX_RESULT  in  32  ALU result of the instruction currently held on EX_* outputs
- MEM_VALID, MEM_WE  in  1 each; MEM_RD  in  5; MEM_DATA  in  32  final MEM-stage result (load data included)
- WB_VALID, WB_WE  in  1 each; WB_RD  in  5; WB_DATA  in  32  value being written to register file this cycle
- EX_READY  in  1  execute accepts the current EX_* bundle
- FLUSH  in  1  kill instruction in this stage and the one being offered
- EX_VALID  out  1; EX_PC, EX_IMM, EX_OP1, EX_OP2  out  32 each; EX_RD  out  5; EX_WE, EX_IS_LOAD  out  1 each; EX_CTRL  out  CTRL_W
- BUBBLE_CNT  out  CNT_W  count of load-use bubbles inserted

## Operation
- Reset (RESET=0 at edge): EX_VALID=0, all other EX_* outputs and BUBBLE_CNT = 0. ID_READY is 0 while RESET=0.
- Hazard: hz = EX_VALID & EX_IS_LOAD & EX_WE & EX_RD!=0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- ID_READY = RESET & EX_READY & ~hz (combinational; FLUSH does not gate it).
- Operand select per source (rs1, rs2), in priority order: rs==0 -> 0; EX match (EX_VALID & EX_WE & ~EX_IS_LOAD & EX_RD==rs) -> EX_RESULT; MEM match (MEM_VALID & MEM_WE & MEM_RD==rs) -> MEM_DATA; WB match -> WB_DATA; else RF_DATA.
- Per-edge action, first match wins:
  - FLUSH=1: EX_VALID<=0 (regardless of EX_READY); decode instruction discarded.
  - EX_READY=0: all EX_* hold.
  - hz=1: EX_VALID<=0 (bubble), BUBBLE_CNT+1 saturating at all-ones; decode holds its instruction.
  - ID_VALID=1: capture ID_* into EX_*, operands via select, EX_VALID<=1.
  - else EX_VALID<=0.
- Payload fields update only on capture; on bubble/flush only EX_VALID clears (payload don't-care).
- ID_RD==0 with ID_WE=1 passes through; bypass never matches x0.

## Timing
- Latency: decode handshake (ID_VALID & ID_READY) at edge N -> EX_* valid after edge N.
- Load-use: exactly one bubble per dependent pair when EX_READY=1; dependent instruction captured at N+1 using MEM bypass.
- Back-pressure: EX_READY low holds everything, no bubble counted, ID_READY low.
- FLUSH and hz same cycle: flush wins, counter unchanged.
- Reset mid-operation: outputs cleared at the first edge with RESET=0, regardless of FLUSH/EX_READY.

## Test plan
- Reset: hold RESET=0 two cycles with ID_VALID=1 -> EX_VALID=0, BUBBLE_CNT=0, ID_READY=0.
- Bypass priority: ID_RS1=5, EX, MEM, WB all write x5 with 0x11/0x22/0x33, RF_DATA1=0x44 -> EX_OP1=0x11; drop EX -> 0x22; drop MEM -> 0x33; drop WB -> 0x44; ID_RS1=0 with all matching -> 0.
- Load-use: load to x7 in EX, next ID uses rs2=7 -> one cycle EX_VALID=0, ID_READY=0, BUBBLE_CNT=1; next edge captures EX_OP2=MEM_DATA.
- No false stall: same as above with ID_USES_RS2=0 -> no bubble, captured immediately.
- Back-pressure/flush: EX_READY=0 three cycles -> EX_* constant, ID_READY=0; assert FLUSH with EX_READY=0 -> EX_VALID=0 next edge.
- Saturation: CNT_W=4, force 20 load-use bubbles -> BUBBLE_CNT stops at 15.
